dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle responder for the core's data-memory port: accepts one load/store request at a time from the MEM stage, holds it for a configurable latency, then returns sign/zero-extended load data or commits the store. It replaces the single-cycle data memory behind the pipeline and drives a `stall` that the hazard logic ORs into its own stall, freezing the pipeline while an access is outstanding. Storage is a byte-addressed, little-endian array inside the block.

## Interface
Parameters:
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `ADDR_REAL_WIDTH`, 12: implemented byte-address bits; array holds 2^ADDR_REAL_WIDTH bytes.
- `DATA_WIDTH`, 32: data bus width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder idle, request will be taken this edge.
- `req_we` input 1: 1 = store, 0 = load.
- `req_mode` input 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use bits [1:0] only.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, low-aligned.
- `rsp_valid` output 1: one-cycle response strobe.
- `rsp_rdata` output 32: extended load data, valid only with `rsp_valid` and `req_we`=0 at acceptance.
- `rsp_err` output 1: misaligned access flag, valid with `rsp_valid`.
- `stall` output 1: freeze pipeline.

## Operation
- FSM states IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: `req_ready`=1. On `req_valid`: latch we, mode, addr[ADDR_REAL_WIDTH-1:0], wdata; load counter with LATENCY-1; go to RESP if LATENCY=1, else WAIT.
- WAIT: `req_ready`=0; counter decrements each cycle; when counter is 1, next state is RESP.
- RESP: `rsp_valid`=1 for exactly one cycle. Loads drive `rsp_rdata` from the array at the latched address. Stores write the array on the edge leaving RESP. Next state is IDLE unconditionally; no request is accepted in RESP.
- Load extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through. Byte lane comes from addr[1:0]; halfword lane comes from addr[1].
- Store lanes: B writes byte addr; H writes addr, addr+1; W writes addr..addr+3. Little-endian.
- Address wrap: only the low ADDR_REAL_WIDTH bits are used, so accesses past the top of the array wrap to 0.
- Undefined `req_mode` values (011, 110, 111) are treated as W.
- `stall` = (IDLE and `req_valid`) or WAIT. It is 0 in RESP, so the pipeline advances on the response edge.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `stall`=0 unless `req_valid` is high. Array contents are not reset.
- Request sampled at edge E0. `rsp_valid` is high in the cycle after edge E0+LATENCY-1, giving LATENCY cycles from the first `req_valid` cycle.
- Throughput: one access per LATENCY+1 cycles; `req_ready` returns the cycle after RESP.
- Request inputs are ignored outside IDLE; changes after acceptance have no effect.
- `rst` in WAIT or RESP: return to IDLE, no `rsp_valid`, pending store discarded (no array write).
- `rsp_rdata` and `rsp_err` are 0 whenever `rsp_valid`=0.

## Configuration
- `DMEM_RESP_MISALIGN_CHECK_EN` defined: an H access with addr[0]=1, or a W access with addr[1:0]≠0, completes normally in timing but sets `rsp_err`=1, forces `rsp_rdata`=0, and suppresses the store write.
- Undefined: `rsp_err` is tied 0. Misaligned H/W addresses are aligned down (low bits cleared) and the access is performed.

## Test plan
- LATENCY=2: SW 0xDEADBEEF to 0x100, then LW 0x100 → `rsp_valid` 2 cycles after each request, `rsp_rdata`=0xDEADBEEF, `stall` high for exactly 2 cycles per access.
- SB 0x80 to 0x203, then LB 0x203 → 0xFFFFFF80; LBU 0x203 → 0x00000080; LW 0x200 → byte 3 = 0x80, other bytes unchanged.
- SH 0x1234 to 0x102, then LHU 0x100 / LHU 0x102 / LH 0x102 → 0xXXXX (old value), 0x00001234, 0x00001234. SH 0x8001 to 0x102 then LH 0x102 → 0xFFFF8001.
- Misaligned LW 0x101. With the macro: `rsp_err`=1, `rsp_rdata`=0, and a following SW to 0x101 leaves 0x100 unchanged. Without the macro: data read from 0x100.
- SW 0xAAAA5555 to 0x300 accepted, `rst` pulsed during WAIT → no `rsp_valid`, `req_ready`=1 the cycle after reset, LW 0x300 returns the pre-store value.
- Wrap and LATENCY=1: SW 0x11223344 to 0x1000 (ADDR_REAL_WIDTH=12) then LW 0x000 → 0x11223344. With `req_valid` held continuously, `rsp_valid` toggles every other cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte-addressed data memory behind the MEM stage.
// Optional misaligned-access error reporting: DMEM_RESP_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int LATENCY         = 2,
  parameter int ADDR_REAL_WIDTH = 12,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_mode,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall
);

  localparam int AW    = ADDR_REAL_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_mode;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_is_b;
  logic                  w_is_h;
  logic                  w_is_w;
  logic                  w_err;
  logic [AW-3:0]         w_wa;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ldata;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_unused_addr;

  assign w_unused_addr = ^req_addr[31:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_mode      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_mode  <= req_mode;
            r_addr  <= req_addr[AW-1:0];
            r_wdata <= req_wdata;
            r_cnt   <= CNT_INIT;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Modes 011/11x fall into the word case.
  assign w_is_b = (r_mode[1:0] == 2'b00);
  assign w_is_h = (r_mode[1:0] == 2'b01);
  assign w_is_w = r_mode[1];

`ifdef DMEM_RESP_MISALIGN_CHECK_EN
  assign w_err = (w_is_h & r_addr[0]) |
                 (w_is_w & (r_addr[1:0] != 2'b00));
`else
  assign w_err = 1'b0;
`endif

  assign w_wa   = r_addr[AW-1:2];
  assign w_word = {r_mem[{w_wa, 2'd3}], r_mem[{w_wa, 2'd2}],
                   r_mem[{w_wa, 2'd1}], r_mem[{w_wa, 2'd0}]};
  assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ldata = w_word;
    w_be    = 4'b1111;
    w_wd    = r_wdata;
    unique case (1'b1)
      w_is_b: begin
        w_ldata = {{24{~r_mode[2] & w_byte[7]}}, w_byte};
        w_be    = 4'b0001 << r_addr[1:0];
        w_wd    = {4{r_wdata[7:0]}};
      end
      w_is_h: begin
        w_ldata = {{16{~r_mode[2] & w_half[15]}}, w_half};
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wd    = {2{r_wdata[15:0]}};
      end
      default: begin
        w_ldata = w_word;
        w_be    = 4'b1111;
        w_wd    = r_wdata;
      end
    endcase
  end

  // Store commits on the edge leaving RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RESP && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[{w_wa, 2'(i)}] <= w_wd[8*i +: 8];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign stall     = (r_state == S_IDLE && req_valid) ||
                     (r_state == S_WAIT);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_valid & w_err;
  assign rsp_rdata = (r_rsp_valid && !r_we && !w_err) ? w_ldata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances checked
// against a byte-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        sel;

  logic        rv0, rv1;
  logic        rdy0, rdy1, vld0, vld1, err0, err1, st0, st1;
  logic [31:0] rd0, rd1;
  logic        rdy, vld, err, stl;
  logic [31:0] rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mm [2][4096];

  always #5 clk = ~clk;

  assign rv0   = req_valid & ~sel;
  assign rv1   = req_valid & sel;
  assign rdy   = sel ? rdy1 : rdy0;
  assign vld   = sel ? vld1 : vld0;
  assign err   = sel ? err1 : err0;
  assign stl   = sel ? st1  : st0;
  assign rdata = sel ? rd1  : rd0;

  dmem_responder #(.LATENCY(2)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv0),
    .req_ready (rdy0),
    .req_we    (req_we),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (vld0),
    .rsp_rdata (rd0),
    .rsp_err   (err0),
    .stall     (st0)
  );

  dmem_responder #(.LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv1),
    .req_ready (rdy1),
    .req_we    (req_we),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (vld1),
    .rsp_rdata (rd1),
    .rsp_err   (err1),
    .stall     (st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Access as a list of bytes: size from mode, wrap at 4 KiB, align down.
  task automatic model(input bit d, input bit we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit e);
    int size;
    int a;
    logic [31:0] v;
    size = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
    a = int'(addr % 4096);
    e = 1'b0;
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
    e = ((a % size) != 0);
`endif
    a = a - (a % size);
    rd = '0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < size; i++) mm[d][a+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(mm[d][a+i]) << (8*i));
      if (size < 4 && !mode[2] && v[8*size-1])
        v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endtask

  task automatic access(input bit we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input string tag);
    logic [31:0] ed;
    bit ee;
    int n;
    int stalls;
    int lat;
    lat = sel ? 1 : 2;
    model(sel, we, mode, addr, wd, ed, ee);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    chk({tag, ".ready"}, 32'(rdy), 32'd1);
    n = 0;
    stalls = 0;
    while (vld !== 1'b1 && n < 40) begin
      if (stl === 1'b1) stalls++;
      @(negedge clk);
      if (n == 0) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_mode  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".stalls"}, 32'(stalls), 32'(lat));
    chk({tag, ".rspstall"}, 32'(stl), 32'd0);
    chk({tag, ".rspready"}, 32'(rdy), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'(ee));
    if (!we) chk({tag, ".rdata"}, rdata, ed);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_mode = 3'b010;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.ready", 32'(rdy0), 32'd1);
    chk("reset.valid", 32'(vld0), 32'd0);
    chk("reset.rdata", rd0, 32'd0);
    chk("reset.err", 32'(err0), 32'd0);
    chk("reset.stall", 32'(st0), 32'd0);
    req_valid = 1'b1;
    #1;
    chk("reset.stallreq", 32'(st0), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Known contents for the regions the directed and random loads use.
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 4; w++)
        access(1'b1, 3'b010, 32'(b*256 + w*4), $urandom, "init");

    access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, "sw100");
    access(1'b0, 3'b010, 32'h100, 32'h0, "lw100");
    chk("lw100.const", rd0, 32'hDEAD_BEEF);

    access(1'b1, 3'b000, 32'h203, 32'h0000_0080, "sb203");
    access(1'b0, 3'b000, 32'h203, 32'h0, "lb203");
    access(1'b0, 3'b100, 32'h203, 32'h0, "lbu203");
    access(1'b0, 3'b010, 32'h200, 32'h0, "lw200");

    access(1'b1, 3'b001, 32'h102, 32'h0000_1234, "sh102");
    access(1'b0, 3'b101, 32'h100, 32'h0, "lhu100");
    access(1'b0, 3'b101, 32'h102, 32'h0, "lhu102");
    access(1'b0, 3'b001, 32'h102, 32'h0, "lh102");
    access(1'b1, 3'b001, 32'h102, 32'h0000_8001, "sh8001");
    access(1'b0, 3'b001, 32'h102, 32'h0, "lh8001");
    chk("lh8001.const", rd0, 32'hFFFF_8001);

    access(1'b0, 3'b010, 32'h101, 32'h0, "lwmis");
    access(1'b1, 3'b010, 32'h101, 32'h5A5A_5A5A, "swmis");
    access(1'b0, 3'b010, 32'h100, 32'h0, "lwafter");

    // Reset while a store waits: no response, no write.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_mode  = 3'b010;
    req_addr  = 32'h300;
    req_wdata = 32'hAAAA_5555;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rstwait.stall", 32'(st0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstwait.valid", 32'(vld0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rstwait.ready", 32'(rdy0), 32'd1);
    chk("rstwait.novalid", 32'(vld0), 32'd0);
    access(1'b0, 3'b010, 32'h300, 32'h0, "rstwait.lw");

    // Randomized traffic on the LATENCY=2 instance.
    for (int k = 0; k < 60; k++)
      access(1'(($urandom_range(0, 2)) == 0), 3'($urandom),
             32'($urandom_range(0, 3) * 256 + $urandom_range(0, 15)),
             $urandom, "rand");

    // LATENCY=1: wrap then back-to-back throughput.
    sel = 1'b1;
    access(1'b1, 3'b010, 32'h1000, 32'h1122_3344, "swwrap");
    access(1'b0, 3'b010, 32'h000, 32'h0, "lwwrap");
    chk("lwwrap.const", rd1, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_mode  = 3'b010;
    req_addr  = 32'h0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("thru.valid", 32'(vld1), 32'(i % 2));
      if (i % 2 == 1) chk("thru.rdata", rd1, 32'h1122_3344);
      @(negedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
